// File: rtl/game_motion_pkg.sv
// Shared motion types and screen constants for game objects.
package game_motion_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEP,
        LIMITS
    } motion_state_t;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;
    localparam int SAFETY  = 2;

    // Arithmetic shift floors toward -inf, so off-screen-left positions stay monotonic.
    function automatic logic [10:0] fp_to_px(input logic signed [31:0] pos, input int unsigned shift);
        return 11'(pos >>> shift);
    endfunction

endpackage

// File: rtl/projectile_move_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after i_sig rises.
module rise_detect (
    input  logic clk,
    input  logic resetN,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prev <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            o_rise <= i_sig & ~r_prev;
        end
    end

endmodule

// File: rtl/projectile_move.sv
// Fixed-point projectile engine: launch, per-frame gravity step, walls, ground, hit and timeout.
// Optional damped ground bounce is enabled by defining BIRD_BOUNCE_EN.
module projectile_move
    import game_motion_pkg::*;
#(
    parameter int FP_SHIFT    = 6,
    parameter int SPEED_W     = 11,
    parameter int Y_ACCEL     = 10,
    parameter int MAX_Y_SPEED = 200,
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32,
    parameter int MAX_FLIGHT  = 255
`ifdef BIRD_BOUNCE_EN
    , parameter int MAX_BOUNCES = 3
`endif
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               fire,
    input  logic [SPEED_W-1:0] launch_vx,
    input  logic [SPEED_W-1:0] launch_vy,
    input  logic [10:0]        start_x,
    input  logic [10:0]        start_y,
    input  logic               collision,
    output logic [10:0]        topLeftX,
    output logic [10:0]        topLeftY,
    output logic               in_flight,
    output logic               hit_pulse,
    output logic               land_pulse,
    output logic               timeout_pulse
);

    localparam int LEFT_FP   = SAFETY * (1 << FP_SHIFT);
    localparam int RIGHT_FP  = (FRAME_W - 1 - SAFETY - OBJ_W) * (1 << FP_SHIFT);
    localparam int BOTTOM_FP = (FRAME_H - 1 - SAFETY - OBJ_H) * (1 << FP_SHIFT);
    localparam int CNT_W     = $clog2(MAX_FLIGHT + 1);

    motion_state_t      r_state;
    logic signed [31:0] r_xpos, r_ypos, r_xspd, r_yspd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_coll;
    logic               w_fire_rise;
    logic signed [31:0] w_start_x_fp, w_start_y_fp;
    logic signed [31:0] w_ysum, w_ynext, w_xabs;
`ifdef BIRD_BOUNCE_EN
    localparam int BNC_W = $clog2(MAX_BOUNCES + 1);
    logic [BNC_W-1:0]   r_bounces;
    logic signed [31:0] w_yabs;
    assign w_yabs = r_yspd[31] ? -r_yspd : r_yspd;
`endif

    rise_detect u_fire_edge (
        .clk    (clk),
        .resetN (resetN),
        .i_sig  (fire),
        .o_rise (w_fire_rise)
    );

    assign w_start_x_fp = {{21{start_x[10]}}, start_x} << FP_SHIFT;
    assign w_start_y_fp = {{21{start_y[10]}}, start_y} << FP_SHIFT;
    assign w_ysum       = r_yspd + Y_ACCEL;
    assign w_ynext      = (w_ysum > MAX_Y_SPEED) ? MAX_Y_SPEED : w_ysum;
    assign w_xabs       = r_xspd[31] ? -r_xspd : r_xspd;
    assign topLeftX     = fp_to_px(r_xpos, FP_SHIFT);
    assign topLeftY     = fp_to_px(r_ypos, FP_SHIFT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_xspd        <= '0;
            r_yspd        <= '0;
            r_cnt         <= '0;
            r_coll        <= 1'b0;
            in_flight     <= 1'b0;
            hit_pulse     <= 1'b0;
            land_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
`ifdef BIRD_BOUNCE_EN
            r_bounces     <= '0;
`endif
        end else begin
            hit_pulse     <= 1'b0;
            land_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_xpos <= w_start_x_fp;
                    r_ypos <= w_start_y_fp;
                    if (w_fire_rise) begin
                        r_xspd    <= {{(32-SPEED_W){launch_vx[SPEED_W-1]}}, launch_vx};
                        r_yspd    <= {{(32-SPEED_W){launch_vy[SPEED_W-1]}}, launch_vy};
                        r_cnt     <= '0;
                        r_coll    <= 1'b0;
                        in_flight <= 1'b1;
                        r_state   <= WAIT;
`ifdef BIRD_BOUNCE_EN
                        r_bounces <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (collision)
                        r_coll <= 1'b1;
                    if (startOfFrame)
                        r_state <= STEP;
                end
                STEP: begin
                    r_yspd  <= w_ynext;
                    r_xpos  <= r_xpos + r_xspd;
                    r_ypos  <= r_ypos + r_yspd;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= LIMITS;
                end
                LIMITS: begin
                    r_state <= WAIT;
                    if (r_coll) begin
                        hit_pulse <= 1'b1;
                        in_flight <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_cnt == CNT_W'(MAX_FLIGHT)) begin
                        timeout_pulse <= 1'b1;
                        in_flight     <= 1'b0;
                        r_state       <= IDLE;
                    end else if (r_ypos > BOTTOM_FP) begin
`ifdef BIRD_BOUNCE_EN
                        if (r_bounces < BNC_W'(MAX_BOUNCES) && w_yabs >= Y_ACCEL) begin
                            r_ypos    <= BOTTOM_FP;
                            r_yspd    <= -(r_yspd >>> 1);
                            r_xspd    <= r_xspd >>> 1;
                            r_bounces <= r_bounces + BNC_W'(1);
                        end else begin
                            land_pulse <= 1'b1;
                            in_flight  <= 1'b0;
                            r_state    <= IDLE;
                        end
`else
                        land_pulse <= 1'b1;
                        in_flight  <= 1'b0;
                        r_state    <= IDLE;
`endif
                    // Clamp and force direction so a wall never re-triggers next frame.
                    end else if (r_xpos < LEFT_FP) begin
                        r_xpos <= LEFT_FP;
                        r_xspd <= w_xabs;
                    end else if (r_xpos > RIGHT_FP) begin
                        r_xpos <= RIGHT_FP;
                        r_xspd <= -w_xabs;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
